// File: rtl/rv32i_types.sv
// Shared RV32I definitions: opcodes and the branch-predictor counter type.
package rv32i_types;

  localparam logic [6:0] br_opcode   = 7'b1100011;
  localparam logic [6:0] jal_opcode  = 7'b1101111;
  localparam logic [6:0] jalr_opcode = 7'b1100111;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_INIT = 2'b01;
  localparam bp_ctr_t BP_CTR_MAX  = 2'b11;
  localparam bp_ctr_t BP_CTR_MIN  = 2'b00;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic bp_ctr_t bp_ctr_update(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != BP_CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != BP_CTR_MIN) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2**GHR_BITS saturating 2-bit counters,
// one combinational read port and one synchronous update port.
module gshare_pht
  import rv32i_types::*;
#(
  parameter int GHR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [GHR_BITS-1:0] rd_idx,
  output bp_ctr_t             rd_ctr,
  input  logic                upd_en,
  input  logic [GHR_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int ENTRIES = 2 ** GHR_BITS;

  bp_ctr_t pht_reg [ENTRIES];
  bp_ctr_t upd_next;

  // Read returns the stored value; a same-cycle update is not bypassed.
  assign rd_ctr = pht_reg[rd_idx];

  always_comb begin
    upd_next = bp_ctr_update(pht_reg[upd_idx], upd_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht_reg[i] <= BP_CTR_INIT;
    end else if (upd_en) begin
      pht_reg[upd_idx] <= upd_next;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC^GHR indexed PHT lookup at fetch,
// training and committed-history update at ROB commit, plus perf counters.
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int GHR_BITS  = 8,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          fetch_pc,
  output logic                 gshare_take,
  output logic [GHR_BITS-1:0]  fetch_pht_idx,
  input  logic                 rob_pop,
  input  logic [6:0]           commit_opcode,
  input  logic                 take_branch,
  input  logic [GHR_BITS-1:0]  commit_pht_idx,
  input  logic                 commit_mispredict,
  output logic [GHR_BITS-1:0]  ghr,
  output logic [PERF_BITS-1:0] br_commit_cnt,
  output logic [PERF_BITS-1:0] br_mispred_cnt
);

  logic [GHR_BITS-1:0]  ghr_reg;
  logic [PERF_BITS-1:0] commit_cnt_reg;
  logic [PERF_BITS-1:0] mispred_cnt_reg;
  logic                 br_commit;
  bp_ctr_t              lookup_ctr;
  logic                 pc_unused;

  assign pc_unused     = ^{fetch_pc[31:GHR_BITS+2], fetch_pc[1:0]};
  assign fetch_pht_idx = fetch_pc[GHR_BITS+1:2] ^ ghr_reg;
  assign gshare_take   = lookup_ctr[1];
  assign br_commit     = rob_pop && (commit_opcode == br_opcode);

  gshare_pht #(
    .GHR_BITS(GHR_BITS)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (fetch_pht_idx),
    .rd_ctr   (lookup_ctr),
    .upd_en   (br_commit),
    .upd_idx  (commit_pht_idx),
    .upd_taken(take_branch)
  );

  // History holds only committed outcomes, newest in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_reg <= '0;
    end else if (br_commit) begin
      ghr_reg <= {ghr_reg[GHR_BITS-2:0], take_branch};
    end
  end

  // Perf counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else if (br_commit) begin
      if (!(&commit_cnt_reg)) commit_cnt_reg <= commit_cnt_reg + 1'b1;
      if (commit_mispredict && !(&mispred_cnt_reg)) mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
    end
  end

  assign ghr            = ghr_reg;
  assign br_commit_cnt  = commit_cnt_reg;
  assign br_mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (default build plus a
// PERF_BITS=4 build sharing the same stimulus for counter saturation).
module tb_gshare_predictor;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        rob_pop = 1'b0;
  logic [6:0]  commit_opcode = '0;
  logic        take_branch = 1'b0;
  logic [7:0]  commit_pht_idx = '0;
  logic        commit_mispredict = 1'b0;

  logic        gshare_take;
  logic [7:0]  fetch_pht_idx;
  logic [7:0]  ghr;
  logic [31:0] br_commit_cnt;
  logic [31:0] br_mispred_cnt;

  logic        take4;
  logic [7:0]  idx4;
  logic [7:0]  ghr4;
  logic [3:0]  cnt4;
  logic [3:0]  mis4;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.GHR_BITS(8), .PERF_BITS(32)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc         (fetch_pc),
    .gshare_take      (gshare_take),
    .fetch_pht_idx    (fetch_pht_idx),
    .rob_pop          (rob_pop),
    .commit_opcode    (commit_opcode),
    .take_branch      (take_branch),
    .commit_pht_idx   (commit_pht_idx),
    .commit_mispredict(commit_mispredict),
    .ghr              (ghr),
    .br_commit_cnt    (br_commit_cnt),
    .br_mispred_cnt   (br_mispred_cnt)
  );

  gshare_predictor #(.GHR_BITS(8), .PERF_BITS(4)) u_dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc         (fetch_pc),
    .gshare_take      (take4),
    .fetch_pht_idx    (idx4),
    .rob_pop          (rob_pop),
    .commit_opcode    (commit_opcode),
    .take_branch      (take_branch),
    .commit_pht_idx   (commit_pht_idx),
    .commit_mispredict(commit_mispredict),
    .ghr              (ghr4),
    .br_commit_cnt    (cnt4),
    .br_mispred_cnt   (mis4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else pass_cnt++;
  endtask

  task automatic commit(input logic [6:0] op, input logic pop, input logic [7:0] idx,
                        input logic taken, input logic mis);
    @(negedge clk);
    rob_pop = pop; commit_opcode = op; commit_pht_idx = idx;
    take_branch = taken; commit_mispredict = mis;
    @(posedge clk);
    #1;
    rob_pop = 1'b0;
    $display("commit op=%b pop=%0d idx=0x%02h taken=%0d mis=%0d -> ghr=0x%02h cnt=%0d mis=%0d",
             op, pop, idx, taken, mis, ghr, br_commit_cnt, br_mispred_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rob_pop = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then every entry weakly not-taken with ghr=0.
    #2;
    check("rst_take", gshare_take, 0);
    check("rst_ghr", ghr, 0);
    check("rst_cnt", br_commit_cnt, 0);
    check("rst_mis", br_mispred_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lookup(32'(i) << 2);
      check("init_idx", fetch_pht_idx, 32'(i));
      check("init_take", gshare_take, 0);
    end

    // Train taken at 0x40, then flush history with 8 not-taken at 0x01.
    lookup(32'h100);
    check("train_idx", fetch_pht_idx, 32'h40);
    commit(br_opcode, 1'b1, 8'h40, 1'b1, 1'b0);
    commit(br_opcode, 1'b1, 8'h40, 1'b1, 1'b0);
    check("train_ghr3", ghr, 32'h03);
    for (int i = 0; i < 8; i++) commit(br_opcode, 1'b1, 8'h01, 1'b0, 1'b0);
    lookup(32'h100);
    check("train_ghr0", ghr, 0);
    check("train_take", gshare_take, 1);
    check("train_cnt", br_commit_cnt, 10);
    check("train_mis", br_mispred_cnt, 0);

    // Asynchronous reset between clock edges.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_take", gshare_take, 0);
    check("arst_cnt", br_commit_cnt, 0);
    check("arst_ghr", ghr, 0);
    @(negedge clk); rst_n = 1'b1;
    lookup(32'h100);
    check("arst_forgot", gshare_take, 0);

    // Saturation at 0x10.
    do_reset();
    for (int i = 0; i < 5; i++) commit(br_opcode, 1'b1, 8'h10, 1'b0, 1'b0);
    lookup(32'h40);
    check("sat_ghr", ghr, 0);
    check("sat_take0", gshare_take, 0);
    commit(br_opcode, 1'b1, 8'h10, 1'b1, 1'b0);
    lookup(32'h44);
    check("sat_idx1", fetch_pht_idx, 32'h10);
    check("sat_take1", gshare_take, 0);
    commit(br_opcode, 1'b1, 8'h10, 1'b1, 1'b0);
    lookup(32'h4C);
    check("sat_idx2", fetch_pht_idx, 32'h10);
    check("sat_take2", gshare_take, 1);

    // GHR shift T,N,T,T.
    do_reset();
    commit(br_opcode, 1'b1, 8'h30, 1'b1, 1'b0);
    commit(br_opcode, 1'b1, 8'h30, 1'b0, 1'b0);
    commit(br_opcode, 1'b1, 8'h30, 1'b1, 1'b0);
    commit(br_opcode, 1'b1, 8'h30, 1'b1, 1'b0);
    lookup(32'h0);
    check("ghr_val", ghr, 32'h0B);
    check("ghr_idx", fetch_pht_idx, 32'h0B);

    // Non-branch commits and rob_pop=0 leave all state alone.
    commit(jal_opcode, 1'b1, 8'h05, 1'b1, 1'b1);
    commit(jalr_opcode, 1'b1, 8'h05, 1'b1, 1'b1);
    commit(7'h33, 1'b1, 8'h05, 1'b1, 1'b1);
    commit(br_opcode, 1'b0, 8'h05, 1'b1, 1'b1);
    commit(jal_opcode, 1'b1, 8'h05, 1'b1, 1'b1);
    lookup(32'h38);
    check("filt_idx", fetch_pht_idx, 32'h05);
    check("filt_ghr", ghr, 32'h0B);
    check("filt_cnt", br_commit_cnt, 4);
    check("filt_mis", br_mispred_cnt, 0);
    commit(jalr_opcode, 1'b1, 8'h05, 1'b1, 1'b1);
    lookup(32'h38);
    check("filt_take", gshare_take, 0);

    // Same-cycle lookup/update to 0x22.
    do_reset();
    @(negedge clk);
    fetch_pc = 32'h88; rob_pop = 1'b1; commit_opcode = br_opcode;
    commit_pht_idx = 8'h22; take_branch = 1'b1; commit_mispredict = 1'b0;
    #1;
    check("coll_idx0", fetch_pht_idx, 32'h22);
    check("coll_take0", gshare_take, 0);
    @(posedge clk); #1;
    rob_pop = 1'b0;
    lookup(32'h8C);
    check("coll_idx1", fetch_pht_idx, 32'h22);
    check("coll_take1", gshare_take, 1);

    // Perf counters.
    do_reset();
    commit(br_opcode, 1'b1, 8'h00, 1'b1, 1'b0);
    commit(br_opcode, 1'b1, 8'h00, 1'b0, 1'b1);
    commit(br_opcode, 1'b1, 8'h00, 1'b1, 1'b0);
    check("perf_cnt", br_commit_cnt, 3);
    check("perf_mis", br_mispred_cnt, 1);

    // PERF_BITS=4 saturation.
    do_reset();
    for (int i = 0; i < 15; i++) commit(br_opcode, 1'b1, 8'h00, 1'b0, 1'b1);
    check("p4_cnt15", 32'(cnt4), 32'hF);
    check("p4_mis15", 32'(mis4), 32'hF);
    commit(br_opcode, 1'b1, 8'h00, 1'b0, 1'b1);
    commit(br_opcode, 1'b1, 8'h00, 1'b0, 1'b1);
    check("p4_cnt_hold", 32'(cnt4), 32'hF);
    check("p4_mis_hold", 32'(mis4), 32'hF);
    check("p32_cnt17", br_commit_cnt, 17);
    check("p32_mis17", br_mispred_cnt, 17);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
